// File: rtl/reg_bus_ctrl.sv
// reg_bus_ctrl: sole initiator of transfers on the shared 16-bit register bus.
// Accepts MOV / LDI / LDU / SWAP commands and sequences the per-register
// read, write and upper-byte write strobes plus this block's own bus drive.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, and the command
// fields must stay stable while cmd_valid waits for cmd_ready.
module reg_bus_ctrl #(
  parameter int NREG = 8,
  parameter int SELW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [SELW-1:0] cmd_src,
  input  logic [SELW-1:0] cmd_dst,
  input  logic [15:0]     cmd_imm,
  input  logic [15:0]     bus_in,
  output logic [15:0]     bus_out,
  output logic            bus_oe,
  output logic [NREG-1:0] read_en,
  output logic [NREG-1:0] write_en,
  output logic [NREG-1:0] writeu_en,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [2:0]      dbg_state
);

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_LDU  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXEC = 3'd1,
    SW1  = 3'd2,
    SW2  = 3'd3,
    SW3  = 3'd4
  } state_t;

  state_t          state;
  logic [SELW-1:0] src_q;
  logic [SELW-1:0] dst_q;
  logic [15:0]     temp;
  logic            src_used;
  logic            cmd_bad;

  // One-hot decode of a register index; indices past the last register decode to zero.
  function automatic logic [NREG-1:0] onehot(input logic [SELW-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i] = (int'(idx) == i);
    return v;
  endfunction

  function automatic logic in_range(input logic [SELW-1:0] idx);
    int v;
    v = int'(idx);
    return v < NREG;
  endfunction

  // Only MOV and SWAP read the source field; LDI/LDU ignore it entirely.
  always_comb begin
    src_used = (cmd_op == OP_MOV) || (cmd_op == OP_SWAP);
    cmd_bad  = !in_range(cmd_dst) || (src_used && !in_range(cmd_src));
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Sequencer: every strobe is a register loaded for the cycle it applies to,
  // so the outputs never see the cmd_* inputs combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      temp      <= '0;
      read_en   <= '0;
      write_en  <= '0;
      writeu_en <= '0;
      bus_oe    <= 1'b0;
      bus_out   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      read_en   <= '0;
      write_en  <= '0;
      writeu_en <= '0;
      bus_oe    <= 1'b0;
      bus_out   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            src_q <= cmd_src;
            dst_q <= cmd_dst;
            if (cmd_bad) begin
              // Bad index: one silent EXEC cycle that only reports the error.
              state <= EXEC;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              case (cmd_op)
                OP_MOV: begin
                  read_en  <= onehot(cmd_src);
                  write_en <= onehot(cmd_dst);
                  done     <= 1'b1;
                  state    <= EXEC;
                end
                OP_LDI: begin
                  bus_oe   <= 1'b1;
                  bus_out  <= cmd_imm;
                  write_en <= onehot(cmd_dst);
                  done     <= 1'b1;
                  state    <= EXEC;
                end
                OP_LDU: begin
                  bus_oe    <= 1'b1;
                  bus_out   <= {8'h00, cmd_imm[7:0]};
                  writeu_en <= onehot(cmd_dst);
                  done      <= 1'b1;
                  state     <= EXEC;
                end
                default: begin
                  read_en <= onehot(cmd_src);
                  state   <= SW1;
                end
              endcase
            end
          end
        end
        EXEC: state <= IDLE;
        SW1: begin
          // temp holds the old source; dst is copied into src next.
          temp     <= bus_in;
          read_en  <= onehot(dst_q);
          write_en <= onehot(src_q);
          state    <= SW2;
        end
        SW2: begin
          bus_oe   <= 1'b1;
          bus_out  <= temp;
          write_en <= onehot(dst_q);
          done     <= 1'b1;
          state    <= SW3;
        end
        SW3:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Bench for reg_bus_ctrl: two instances (8 and 6 registers) each with a
// behavioural register bank on its bus, plus an array-level reference model
// of the register contents.
module tb_reg_bus_ctrl;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_LDU  = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared command drive ----------------
  logic        sel   = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [2:0]  src   = 3'd0;
  logic [2:0]  dst   = 3'd0;
  logic [15:0] imm   = 16'h0;
  logic        bank_init = 1'b0;

  logic a_valid, b_valid;
  assign a_valid = valid & ~sel;
  assign b_valid = valid & sel;

  // ---------------- DUT A: 8 registers ----------------
  logic        a_ready, a_oe, a_busy, a_done, a_err;
  logic [15:0] a_out, a_bus;
  logic [7:0]  a_rd, a_we, a_weu;
  logic [2:0]  a_dbg;

  reg_bus_ctrl #(.NREG(8)) u_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_op(op), .cmd_src(src), .cmd_dst(dst), .cmd_imm(imm),
    .bus_in(a_bus), .bus_out(a_out), .bus_oe(a_oe),
    .read_en(a_rd), .write_en(a_we), .writeu_en(a_weu),
    .busy(a_busy), .done(a_done), .err(a_err), .dbg_state(a_dbg)
  );

  // ---------------- DUT B: 6 registers ----------------
  logic        b_ready, b_oe, b_busy, b_done, b_err;
  logic [15:0] b_out, b_bus;
  logic [5:0]  b_rd, b_we, b_weu;
  logic [2:0]  b_dbg;

  reg_bus_ctrl #(.NREG(6)) u_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(op), .cmd_src(src), .cmd_dst(dst), .cmd_imm(imm),
    .bus_in(b_bus), .bus_out(b_out), .bus_oe(b_oe),
    .read_en(b_rd), .write_en(b_we), .writeu_en(b_weu),
    .busy(b_busy), .done(b_done), .err(b_err), .dbg_state(b_dbg)
  );

  // ---------------- register banks on each bus ----------------
  logic [15:0] rega [8];
  logic [15:0] regb [6];

  always_comb begin
    a_bus = 16'h0;
    if (a_oe) a_bus = a_out;
    for (int i = 0; i < 8; i++) if (a_rd[i]) a_bus = rega[i];
    b_bus = 16'h0;
    if (b_oe) b_bus = b_out;
    for (int i = 0; i < 6; i++) if (b_rd[i]) b_bus = regb[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!bank_init)      rega[i] <= 16'h0;
      else if (a_we[i])    rega[i] <= a_bus;
      else if (a_weu[i])   rega[i][15:8] <= a_bus[7:0];
    end
    for (int i = 0; i < 6; i++) begin
      if (!bank_init)      regb[i] <= 16'h0;
      else if (b_we[i])    regb[i] <= b_bus;
      else if (b_weu[i])   regb[i][15:8] <= b_bus[7:0];
    end
  end

  // View of whichever DUT the current command targets
  logic        c_ready, c_done, c_err, c_oe;
  logic [15:0] c_out;
  logic [7:0]  c_rd, c_we, c_weu;
  always_comb begin
    c_ready = sel ? b_ready : a_ready;
    c_done  = sel ? b_done  : a_done;
    c_err   = sel ? b_err   : a_err;
    c_oe    = sel ? b_oe    : a_oe;
    c_out   = sel ? b_out   : a_out;
    c_rd    = sel ? {2'b00, b_rd}  : a_rd;
    c_we    = sel ? {2'b00, b_we}  : a_we;
    c_weu   = sel ? {2'b00, b_weu} : a_weu;
  end

  // ---------------- reference model ----------------
  logic [15:0] ea [8];
  logic [15:0] eb [8];

  // Applies one command to the expected register file; returns the expected
  // cycle of done (counted from the handshake) and the expected err flag.
  task automatic model_apply(input logic d, input logic [1:0] o, input logic [2:0] s,
                             input logic [2:0] t, input logic [15:0] im,
                             output int n, output logic e);
    int nreg;
    bit su;
    logic [15:0] m [8];
    logic [15:0] x;
    nreg = d ? 6 : 8;
    su = (o == OP_MOV) || (o == OP_SWAP);
    e = (int'(t) >= nreg) || (su && int'(s) >= nreg);
    n = (e || o != OP_SWAP) ? 1 : 3;
    if (e) return;
    for (int i = 0; i < 8; i++) m[i] = d ? eb[i] : ea[i];
    case (o)
      OP_MOV:  m[t] = m[s];
      OP_LDI:  m[t] = im;
      OP_LDU:  m[t][15:8] = im[7:0];
      default: begin x = m[s]; m[s] = m[t]; m[t] = x; end
    endcase
    for (int i = 0; i < 8; i++) begin
      if (d) eb[i] = m[i];
      else   ea[i] = m[i];
    end
  endtask

  // ---------------- invariant monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      checks += 4;
      if ($countones(a_rd) > 1 || $countones(b_rd) > 1) begin
        failures++; $display("FAIL inv_read_onehot a_rd=%b b_rd=%b", a_rd, b_rd);
      end
      if ((a_oe && a_rd != 0) || (b_oe && b_rd != 0)) begin
        failures++; $display("FAIL inv_oe_vs_read a_oe=%b a_rd=%b b_oe=%b b_rd=%b", a_oe, a_rd, b_oe, b_rd);
      end
      if ((a_we != 0 && a_weu != 0) || (b_we != 0 && b_weu != 0)) begin
        failures++; $display("FAIL inv_we_vs_weu a_we=%b a_weu=%b b_we=%b b_weu=%b", a_we, a_weu, b_we, b_weu);
      end
      if ((a_ready && (a_rd != 0 || a_we != 0 || a_weu != 0 || a_oe)) ||
          (b_ready && (b_rd != 0 || b_we != 0 || b_weu != 0 || b_oe))) begin
        failures++; $display("FAIL inv_idle_quiet a_rd=%b a_we=%b a_weu=%b a_oe=%b b_rd=%b b_we=%b b_weu=%b b_oe=%b",
                             a_rd, a_we, a_weu, a_oe, b_rd, b_we, b_weu, b_oe);
      end
    end
  end

  // ---------------- driver ----------------
  logic [7:0]  tr_rd  [6];
  logic [7:0]  tr_we  [6];
  logic [7:0]  tr_weu [6];
  logic        tr_oe  [6];
  logic [15:0] tr_out [6];
  int          got_n;
  logic        got_err;

  // Issues one command, records the strobes of each execution cycle until
  // done, then returns one cycle later (after the final write has landed).
  task automatic run_cmd(input logic d, input logic [1:0] o, input logic [2:0] s,
                         input logic [2:0] t, input logic [15:0] im);
    bit ok;
    for (int i = 0; i < 6; i++) begin
      tr_rd[i] = 0; tr_we[i] = 0; tr_weu[i] = 0; tr_oe[i] = 0; tr_out[i] = 0;
    end
    got_n = 0; got_err = 0;
    @(negedge clk);
    sel = d; op = o; src = s; dst = t; imm = im; valid = 1'b1;
    #1;
    ok = 0;
    for (int w = 0; w < 20; w++) begin
      if (c_ready) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    checks++;
    if (!ok) begin
      failures++; $display("FAIL handshake_timeout cmd_ready=%b required=1", c_ready);
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tr_rd[k-1] = c_rd; tr_we[k-1] = c_we; tr_weu[k-1] = c_weu;
      tr_oe[k-1] = c_oe; tr_out[k-1] = c_out;
      if (c_done) begin got_n = k; got_err = c_err; break; end
      @(negedge clk);
    end
    checks++;
    if (got_n == 0) begin
      failures++; $display("FAIL done_timeout done never seen within 6 cycles");
    end
    @(negedge clk);
    checks++;
    if (c_done !== 1'b0 || c_err !== 1'b0 || c_ready !== 1'b1) begin
      failures++; $display("FAIL done_pulse done=%b err=%b ready=%b required 0 0 1", c_done, c_err, c_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks += 3;
    if (a_ready !== 1'b1 || a_busy !== 1'b0 || b_ready !== 1'b1 || b_busy !== 1'b0) begin
      failures++; $display("FAIL reset_ready a_ready=%b a_busy=%b b_ready=%b b_busy=%b required 1 0 1 0", a_ready, a_busy, b_ready, b_busy);
    end
    if (a_rd !== 0 || a_we !== 0 || a_weu !== 0 || a_oe !== 0 || a_out !== 16'h0) begin
      failures++; $display("FAIL reset_strobes rd=%b we=%b weu=%b oe=%b out=%h required all 0", a_rd, a_we, a_weu, a_oe, a_out);
    end
    if (a_done !== 0 || a_err !== 0 || b_done !== 0 || b_err !== 0) begin
      failures++; $display("FAIL reset_done a_done=%b a_err=%b b_done=%b b_err=%b required 0", a_done, a_err, b_done, b_err);
    end
    bank_init = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release a_ready=%b b_ready=%b required 1", a_ready, b_ready);
    end
  endtask

  task automatic test_ldi_mov;
    int n; logic e;
    model_apply(0, OP_LDI, 3'd0, 3'd3, 16'hBEEF, n, e);
    run_cmd(0, OP_LDI, 3'd0, 3'd3, 16'hBEEF);
    checks += 2;
    if (got_n != 1 || got_err !== 1'b0) begin
      failures++; $display("FAIL ldi_timing done_cycle=%0d err=%b required 1 0", got_n, got_err);
    end
    if (tr_oe[0] !== 1'b1 || tr_out[0] !== 16'hBEEF || tr_we[0] !== 8'b0000_1000 || tr_rd[0] !== 8'h00 || tr_weu[0] !== 8'h00) begin
      failures++; $display("FAIL ldi_strobes oe=%b out=%h we=%b rd=%b weu=%b required 1 beef 00001000 0 0",
                           tr_oe[0], tr_out[0], tr_we[0], tr_rd[0], tr_weu[0]);
    end
    model_apply(0, OP_MOV, 3'd3, 3'd5, 16'h0, n, e);
    run_cmd(0, OP_MOV, 3'd3, 3'd5, 16'h0);
    checks += 2;
    if (tr_rd[0] !== 8'b0000_1000 || tr_we[0] !== 8'b0010_0000 || tr_oe[0] !== 1'b0) begin
      failures++; $display("FAIL mov_strobes rd=%b we=%b oe=%b required 00001000 00100000 0", tr_rd[0], tr_we[0], tr_oe[0]);
    end
    if (rega[5] !== 16'hBEEF || rega[5] !== ea[5]) begin
      failures++; $display("FAIL mov_result reg5=%h required beef", rega[5]);
    end
  endtask

  task automatic test_ldu;
    int n; logic e;
    model_apply(0, OP_LDI, 3'd0, 3'd2, 16'h00AA, n, e);
    run_cmd(0, OP_LDI, 3'd0, 3'd2, 16'h00AA);
    model_apply(0, OP_LDU, 3'd0, 3'd2, 16'h1234, n, e);
    run_cmd(0, OP_LDU, 3'd0, 3'd2, 16'h1234);
    checks += 2;
    if (got_n != 1 || tr_weu[0] !== 8'b0000_0100 || tr_we[0] !== 8'h00 || tr_oe[0] !== 1'b1 || tr_out[0] !== 16'h0034) begin
      failures++; $display("FAIL ldu_strobes n=%0d weu=%b we=%b oe=%b out=%h required 1 00000100 0 1 0034",
                           got_n, tr_weu[0], tr_we[0], tr_oe[0], tr_out[0]);
    end
    if (rega[2] !== 16'h34AA || rega[2] !== ea[2]) begin
      failures++; $display("FAIL ldu_result reg2=%h required 34aa", rega[2]);
    end
  endtask

  task automatic test_swap;
    int n; logic e;
    model_apply(0, OP_LDI, 3'd0, 3'd1, 16'h1111, n, e);
    run_cmd(0, OP_LDI, 3'd0, 3'd1, 16'h1111);
    model_apply(0, OP_LDI, 3'd0, 3'd6, 16'h6666, n, e);
    run_cmd(0, OP_LDI, 3'd0, 3'd6, 16'h6666);
    model_apply(0, OP_SWAP, 3'd1, 3'd6, 16'h0, n, e);
    run_cmd(0, OP_SWAP, 3'd1, 3'd6, 16'h0);
    checks += 5;
    if (got_n != 3 || got_err !== 1'b0) begin
      failures++; $display("FAIL swap_timing done_cycle=%0d err=%b required 3 0", got_n, got_err);
    end
    if (tr_rd[0] !== 8'b0000_0010 || tr_we[0] !== 8'h00 || tr_oe[0] !== 1'b0) begin
      failures++; $display("FAIL swap_cycle1 rd=%b we=%b oe=%b required 00000010 0 0", tr_rd[0], tr_we[0], tr_oe[0]);
    end
    if (tr_rd[1] !== 8'b0100_0000 || tr_we[1] !== 8'b0000_0010 || tr_oe[1] !== 1'b0) begin
      failures++; $display("FAIL swap_cycle2 rd=%b we=%b oe=%b required 01000000 00000010 0", tr_rd[1], tr_we[1], tr_oe[1]);
    end
    if (tr_rd[2] !== 8'h00 || tr_we[2] !== 8'b0100_0000 || tr_oe[2] !== 1'b1 || tr_out[2] !== 16'h1111) begin
      failures++; $display("FAIL swap_cycle3 rd=%b we=%b oe=%b out=%h required 0 01000000 1 1111", tr_rd[2], tr_we[2], tr_oe[2], tr_out[2]);
    end
    if (rega[1] !== 16'h6666 || rega[6] !== 16'h1111) begin
      failures++; $display("FAIL swap_result reg1=%h reg6=%h required 6666 1111", rega[1], rega[6]);
    end
    // src == dst takes the full three cycles and leaves the value alone
    model_apply(0, OP_SWAP, 3'd6, 3'd6, 16'h0, n, e);
    run_cmd(0, OP_SWAP, 3'd6, 3'd6, 16'h0);
    checks++;
    if (got_n != 3 || rega[6] !== ea[6]) begin
      failures++; $display("FAIL swap_self done_cycle=%0d reg6=%h required 3 %h", got_n, rega[6], ea[6]);
    end
  endtask

  task automatic test_range;
    int n; logic e;
    model_apply(1, OP_LDI, 3'd0, 3'd0, 16'hC0DE, n, e);
    run_cmd(1, OP_LDI, 3'd0, 3'd0, 16'hC0DE);
    model_apply(1, OP_MOV, 3'd7, 3'd0, 16'h0, n, e);
    run_cmd(1, OP_MOV, 3'd7, 3'd0, 16'h0);
    checks += 3;
    if (got_n != 1 || got_err !== 1'b1) begin
      failures++; $display("FAIL range_mov done_cycle=%0d err=%b required 1 1", got_n, got_err);
    end
    if (tr_rd[0] !== 8'h00 || tr_we[0] !== 8'h00 || tr_weu[0] !== 8'h00 || tr_oe[0] !== 1'b0) begin
      failures++; $display("FAIL range_quiet rd=%b we=%b weu=%b oe=%b required all 0", tr_rd[0], tr_we[0], tr_weu[0], tr_oe[0]);
    end
    if (regb[0] !== 16'hC0DE) begin
      failures++; $display("FAIL range_reg0 reg0=%h required c0de", regb[0]);
    end
    model_apply(1, OP_SWAP, 3'd1, 3'd6, 16'h0, n, e);
    run_cmd(1, OP_SWAP, 3'd1, 3'd6, 16'h0);
    checks++;
    if (got_n != 1 || got_err !== 1'b1 || tr_rd[0] !== 8'h00) begin
      failures++; $display("FAIL range_swap done_cycle=%0d err=%b rd=%b required 1 1 0", got_n, got_err, tr_rd[0]);
    end
    // LDI ignores its source field, so a wild src is not an error
    model_apply(1, OP_LDI, 3'd7, 3'd5, 16'h5555, n, e);
    run_cmd(1, OP_LDI, 3'd7, 3'd5, 16'h5555);
    checks++;
    if (got_err !== 1'b0 || regb[5] !== 16'h5555) begin
      failures++; $display("FAIL range_ldi_src err=%b reg5=%h required 0 5555", got_err, regb[5]);
    end
  endtask

  task automatic test_back_to_back;
    int acc; int ndone; logic prev_done; logic [15:0] r; int n; logic e;
    int acc_c [4];
    r = 16'($urandom);
    model_apply(0, OP_LDI, 3'd0, 3'd0, r, n, e);
    run_cmd(0, OP_LDI, 3'd0, 3'd0, r);
    for (int i = 0; i < 4; i++) model_apply(0, OP_MOV, 3'(i), 3'(i + 1), 16'h0, n, e);
    @(negedge clk);
    sel = 1'b0; op = OP_MOV; src = 3'd0; dst = 3'd1; valid = 1'b1;
    acc = 0; ndone = 0; prev_done = 1'b0;
    for (int i = 0; i < 4; i++) acc_c[i] = 0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (a_done) begin
        ndone++;
        checks++;
        if (prev_done) begin failures++; $display("FAIL b2b_done_width done high in consecutive cycles at %0d", c); end
      end
      prev_done = a_done;
      if (a_busy) begin
        checks++;
        if (a_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_busy cmd_ready=%b required 0 at %0d", a_ready, c); end
      end
      if (a_ready && acc < 4) begin
        acc_c[acc] = c;
        acc++;
        @(posedge clk); #1;
        if (acc < 4) begin src = 3'(acc); dst = 3'(acc + 1); end
        else valid = 1'b0;
      end
    end
    checks += 3;
    if (acc != 4 || ndone != 4) begin
      failures++; $display("FAIL b2b_count accepted=%0d dones=%0d required 4 4", acc, ndone);
    end
    if (acc_c[1] - acc_c[0] != 2 || acc_c[2] - acc_c[1] != 2 || acc_c[3] - acc_c[2] != 2) begin
      failures++; $display("FAIL b2b_spacing accept cycles %0d %0d %0d %0d required step 2", acc_c[0], acc_c[1], acc_c[2], acc_c[3]);
    end
    if (rega[1] !== r || rega[2] !== r || rega[3] !== r || rega[4] !== ea[4]) begin
      failures++; $display("FAIL b2b_result regs1..4=%h %h %h %h required %h", rega[1], rega[2], rega[3], rega[4], r);
    end
  endtask

  task automatic test_random;
    logic d; logic [1:0] o; logic [2:0] s, t; logic [15:0] im; int n; logic e; int nreg;
    for (int it = 0; it < 40; it++) begin
      d  = 1'($urandom_range(0, 1));
      o  = 2'($urandom_range(0, 3));
      s  = 3'($urandom_range(0, 7));
      t  = 3'($urandom_range(0, 7));
      im = 16'($urandom);
      model_apply(d, o, s, t, im, n, e);
      run_cmd(d, o, s, t, im);
      checks += 2;
      if (got_n != n || got_err !== e) begin
        failures++; $display("FAIL rand_timing it=%0d dut=%0d op=%0d src=%0d dst=%0d done_cycle=%0d err=%b required %0d %b",
                             it, d, o, s, t, got_n, got_err, n, e);
      end
      nreg = d ? 6 : 8;
      for (int i = 0; i < nreg; i++) begin
        if ((d ? regb[i] : rega[i]) !== (d ? eb[i] : ea[i])) begin
          failures++;
          $display("FAIL rand_regs it=%0d dut=%0d reg%0d=%h required %h", it, d, i, d ? regb[i] : rega[i], d ? eb[i] : ea[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_reset_mid_swap;
    @(negedge clk);
    sel = 1'b0; op = OP_SWAP; src = 3'd1; dst = 3'd6; valid = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL midrst_start cmd_ready=%b required 1", a_ready); end
    @(posedge clk);
    @(negedge clk);              // first swap cycle
    valid = 1'b0;
    @(negedge clk);              // second swap cycle
    checks++;
    if (a_rd !== 8'b0100_0000 || a_we !== 8'b0000_0010) begin
      failures++; $display("FAIL midrst_sw2 rd=%b we=%b required 01000000 00000010", a_rd, a_we);
    end
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (a_rd !== 0 || a_we !== 0 || a_weu !== 0 || a_oe !== 0 || a_out !== 16'h0) begin
      failures++; $display("FAIL midrst_strobes rd=%b we=%b weu=%b oe=%b out=%h required all 0", a_rd, a_we, a_weu, a_oe, a_out);
    end
    if (a_busy !== 1'b0 || a_ready !== 1'b1 || a_done !== 1'b0) begin
      failures++; $display("FAIL midrst_state busy=%b ready=%b done=%b required 0 1 0", a_busy, a_ready, a_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      failures++; $display("FAIL midrst_release ready=%b busy=%b required 1 0", a_ready, a_busy);
    end
    run_cmd(0, OP_LDI, 3'd0, 3'd4, 16'h5A5A);
    checks++;
    if (got_n != 1 || rega[4] !== 16'h5A5A) begin
      failures++; $display("FAIL midrst_after done_cycle=%0d reg4=%h required 1 5a5a", got_n, rega[4]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 8; i++) begin ea[i] = 16'h0; eb[i] = 16'h0; end
    test_reset;
    test_ldi_mov;
    test_ldu;
    test_swap;
    test_range;
    test_back_to_back;
    test_random;
    test_reset_mid_swap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
